// File: rtl/ls_gate_bank.sv
// ls_gate_bank
// Bank of CHANNELS identical logic gates, each reducing INPUTS bits with one
// shared function selected by mode. Results pass through a PIPE-deep pipeline
// whose last stage is the output register, and a saturating 8-bit counter per
// channel records how often that channel's output bit changed.
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous active-high reset (priority over ce and cnt_clr)
//   ce         clock enable; 0 freezes every register
//   in_valid   qualifies a/mode on an enabled edge
//   mode       0 NAND, 1 AND, 2 NOR, 3 OR, 4 XOR, 5 XNOR, 6/7 NAND
//   a          gate inputs, channel c uses a[c*INPUTS +: INPUTS]
//   y          registered gate outputs, bit c = channel c
//   out_valid  y carries a new result this cycle
//   cnt_sel    channel select for counter readback
//   cnt_clr    clears all transition counters (only when ce=1)
//   cnt        transition count of channel cnt_sel, 0 when out of range
//
// Handshake: there is no back-pressure. A sample is accepted on every rising
// edge where ce=1 and in_valid=1; the result leaves exactly PIPE enabled edges
// later (the accepting edge counts as the first) with out_valid=1 for one
// enabled cycle. ce=0 stalls the whole pipeline in place.

module ls_gate_bank #(
  parameter int CHANNELS = 4,
  parameter int INPUTS   = 2,
  parameter int PIPE     = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ce,
  input  logic                         in_valid,
  input  logic [2:0]                   mode,
  input  logic [CHANNELS*INPUTS-1:0]   a,
  output logic [CHANNELS-1:0]          y,
  output logic                         out_valid,
  input  logic [3:0]                   cnt_sel,
  input  logic                         cnt_clr,
  output logic [7:0]                   cnt
);

  // Gate evaluation on the incoming sample, so the mode used is always the
  // one presented together with that sample.
  logic [CHANNELS-1:0] gate_out;

  always_comb begin
    gate_out = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      case (mode)
        3'd1:    gate_out[c] =  (&a[c*INPUTS +: INPUTS]);
        3'd2:    gate_out[c] = ~(|a[c*INPUTS +: INPUTS]);
        3'd3:    gate_out[c] =  (|a[c*INPUTS +: INPUTS]);
        3'd4:    gate_out[c] =  (^a[c*INPUTS +: INPUTS]);
        3'd5:    gate_out[c] = ~(^a[c*INPUTS +: INPUTS]);
        default: gate_out[c] = ~(&a[c*INPUTS +: INPUTS]);
      endcase
    end
  end

  // Pipeline: stage PIPE-1 is the output register. Each stage only loads data
  // when the sample entering it is valid, so the last stage naturally holds
  // the previous result across bubbles.
  logic [CHANNELS-1:0] pipe_data [PIPE];
  logic [PIPE-1:0]     pipe_vld;

  // What each stage will see on the next enabled edge.
  logic [CHANNELS-1:0] stage_data [PIPE];
  logic [PIPE-1:0]     stage_vld;

  always_comb begin
    stage_vld     = '0;
    stage_vld[0]  = in_valid;
    stage_data[0] = gate_out;
    for (int i = 1; i < PIPE; i++) begin
      stage_vld[i]  = pipe_vld[i-1];
      stage_data[i] = pipe_data[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld <= '0;
      for (int i = 0; i < PIPE; i++) begin
        pipe_data[i] <= '0;
      end
    end else if (ce) begin
      for (int i = 0; i < PIPE; i++) begin
        pipe_vld[i] <= stage_vld[i];
        if (stage_vld[i]) begin
          pipe_data[i] <= stage_data[i];
        end
      end
    end
  end

  assign y         = pipe_data[PIPE-1];
  assign out_valid = pipe_vld[PIPE-1];

  // Channels whose output bit flips on the next enabled edge.
  logic [CHANNELS-1:0] toggle;

  always_comb begin
    toggle = '0;
    if (stage_vld[PIPE-1]) begin
      toggle = stage_data[PIPE-1] ^ y;
    end
  end

  // Transition counters. Reset only forces y to 0 and zeroes the counters, so
  // the reset transition itself is never counted. cnt_clr wins over a
  // coincident increment.
  logic [7:0] cnt_r [CHANNELS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        cnt_r[c] <= 8'd0;
      end
    end else if (ce) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (cnt_clr) begin
          cnt_r[c] <= 8'd0;
        end else if (toggle[c] && (cnt_r[c] != 8'hFF)) begin
          cnt_r[c] <= cnt_r[c] + 8'd1;
        end
      end
    end
  end

  // Readback mux; selects beyond the last channel read as zero.
  always_comb begin
    cnt = 8'd0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (cnt_sel == 4'(c)) begin
        cnt = cnt_r[c];
      end
    end
  end

endmodule

// File: tb/tb_ls_gate_bank.sv
module tb_ls_gate_bank;

  localparam int CHANNELS = 4;
  localparam int INPUTS   = 2;
  localparam int PIPE     = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                       rst;
  logic                       ce;
  logic                       in_valid;
  logic [2:0]                 mode;
  logic [CHANNELS*INPUTS-1:0] a;
  logic [CHANNELS-1:0]        y;
  logic                       out_valid;
  logic [3:0]                 cnt_sel;
  logic                       cnt_clr;
  logic [7:0]                 cnt;

  ls_gate_bank #(
    .CHANNELS (CHANNELS),
    .INPUTS   (INPUTS),
    .PIPE     (PIPE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .in_valid  (in_valid),
    .mode      (mode),
    .a         (a),
    .y         (y),
    .out_valid (out_valid),
    .cnt_sel   (cnt_sel),
    .cnt_clr   (cnt_clr),
    .cnt       (cnt)
  );

  // ---------------- scoreboard state ----------------
  int         checks   = 0;
  int         failures = 0;
  logic [3:0] exp_q[$];
  logic [3:0] exp_y;
  int         exp_cnt [4];
  int         ov_seen;

  // Hand-computed results for a = 8'b11_10_01_00, modes 0..7.
  logic [3:0] tt [8] = '{4'b0111, 4'b1000, 4'b0001, 4'b1110,
                         4'b0110, 4'b1001, 4'b0111, 4'b0111};

  function automatic logic [3:0] ref_gate(input logic [2:0] m, input logic [7:0] av);
    logic [3:0] r;
    logic [1:0] p;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      p = av[c*2 +: 2];
      case (m)
        3'd1:    r[c] = p[0] & p[1];
        3'd2:    r[c] = ~(p[0] | p[1]);
        3'd3:    r[c] = p[0] | p[1];
        3'd4:    r[c] = p[0] ^ p[1];
        3'd5:    r[c] = ~(p[0] ^ p[1]);
        default: r[c] = ~(p[0] & p[1]);
      endcase
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_emit(input logic [3:0] r);
    for (int c = 0; c < 4; c++) begin
      if (r[c] != exp_y[c] && exp_cnt[c] < 255) exp_cnt[c]++;
    end
    exp_y = r;
  endtask

  // ---------------- driver: one clock edge plus scoreboard update ----------------
  task automatic cycle();
    logic       ce_s;
    logic       rst_s;
    logic       clr_s;
    logic       acc;
    logic [3:0] r;
    logic [3:0] e;
    ce_s  = ce;
    rst_s = rst;
    clr_s = cnt_clr;
    acc   = ce && in_valid && !rst;
    r     = ref_gate(mode, a);
    @(posedge clk);
    #1;
    if (rst_s) begin
      exp_q.delete();
      exp_y = '0;
      for (int c = 0; c < 4; c++) exp_cnt[c] = 0;
    end else begin
      if (acc) exp_q.push_back(r);
      if (ce_s && out_valid) begin
        ov_seen++;
        if (exp_q.size() == 0) begin
          chk("spurious_out_valid", out_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("y_result", y, e);
          model_emit(e);
        end
      end
      if (ce_s && clr_s) begin
        for (int c = 0; c < 4; c++) exp_cnt[c] = 0;
      end
    end
  endtask

  task automatic chk_cnts(input string tag);
    for (int c = 0; c < 4; c++) begin
      cnt_sel = 4'(c);
      #1;
      chk($sformatf("%s_cnt%0d", tag, c), cnt, exp_cnt[c]);
    end
    cnt_sel = 4'd0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; ce = 1'b1; in_valid = 1'b0; mode = 3'd0; a = '0;
    cnt_sel = 4'd0; cnt_clr = 1'b0;
    exp_y = '0; ov_seen = 0;
    for (int c = 0; c < 4; c++) exp_cnt[c] = 0;

    // Reset state
    cycle();
    cycle();
    chk("rst_y", y, 4'b0000);
    chk("rst_out_valid", out_valid, 1'b0);
    chk_cnts("rst");
    rst = 1'b0;
    cycle();

    // Truth table, one isolated accept per mode; mode changes right after accept
    for (int m = 0; m < 8; m++) begin
      a = 8'b11_10_01_00; mode = 3'(m); in_valid = 1'b1;
      cycle();
      in_valid = 1'b0; mode = 3'(7 - m); a = 8'h5A;
      chk("tt_ov_early", out_valid, 1'b0);
      cycle();
      chk("tt_ov", out_valid, 1'b1);
      chk($sformatf("tt_y_mode%0d", m), y, tt[m]);
      cycle();
      chk("tt_ov_pulse", out_valid, 1'b0);
      chk("tt_y_hold", y, tt[m]);
    end
    chk_cnts("tt");

    // Streaming: 16 back-to-back accepts, mode alternating 0/2
    ov_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (i < 16) begin
        in_valid = 1'b1;
        mode = (i % 2 == 1) ? 3'd2 : 3'd0;
        a = 8'($urandom_range(0, 255));
      end else begin
        in_valid = 1'b0;
      end
      cycle();
      chk("stream_ov_slot", out_valid, (i >= 1 && i <= 16) ? 1'b1 : 1'b0);
    end
    chk("stream_count", ov_seen, 16);
    chk("stream_drained", exp_q.size(), 0);
    chk_cnts("stream");

    // Stall: accept, 5 cycles ce=0 (cnt_clr ignored), then resume
    a = 8'b11_11_00_00; mode = 3'd3; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0; ce = 1'b0; cnt_clr = 1'b1; mode = 3'd0; a = '0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("stall_ov", out_valid, 1'b0);
      chk("stall_y", y, exp_y);
    end
    chk_cnts("stall");
    ce = 1'b1; cnt_clr = 1'b0;
    cycle();
    chk("stall_resume_ov", out_valid, 1'b1);
    chk("stall_resume_y", y, 4'b1100);
    cycle();
    chk("stall_ov_pulse", out_valid, 1'b0);

    // Counters: clear, then toggle channel 0 300 times
    cnt_clr = 1'b1;
    cycle();
    cnt_clr = 1'b0;
    chk_cnts("clr");
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'b1; mode = 3'd1;
      a = (i % 2 == 1) ? 8'h03 : 8'h00;
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    cycle();
    cnt_sel = 4'd0; #1;
    chk("sat_cnt0", cnt, 8'd255);
    cnt_sel = 4'd9; #1;
    chk("sel9_cnt", cnt, 8'd0);
    cnt_sel = 4'd4; #1;
    chk("sel4_cnt", cnt, 8'd0);
    chk_cnts("sat");

    // cnt_clr coincident with a toggling y update
    a = 8'h00; mode = 3'd1; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0; cnt_clr = 1'b1;
    cycle();
    cnt_clr = 1'b0;
    chk("clr_coinc_y", y, 4'b0000);
    cnt_sel = 4'd0; #1;
    chk("clr_coinc_cnt0", cnt, 8'd0);

    // Reset mid-flight
    a = 8'hFF; mode = 3'd1; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    cycle();
    cycle();
    chk("pre_rst_y", y, 4'b1111);
    a = 8'h00; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0; rst = 1'b1; cnt_clr = 1'b0;
    cycle();
    rst = 1'b0;
    chk("midrst_y", y, 4'b0000);
    chk("midrst_ov", out_valid, 1'b0);
    for (int c = 0; c < 4; c++) begin
      cnt_sel = 4'(c); #1;
      chk("midrst_cnt", cnt, 8'd0);
    end
    // First sample right after reset release
    a = 8'hC3; mode = 3'd1; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("post_rst_ov_early", out_valid, 1'b0);
    chk("post_rst_y_early", y, 4'b0000);
    cycle();
    chk("post_rst_ov", out_valid, 1'b1);
    chk("post_rst_y", y, 4'b1001);
    cycle();
    chk("post_rst_ov_pulse", out_valid, 1'b0);
    chk_cnts("post_rst");

    // Hold: no valid input, changing a and mode
    for (int i = 0; i < 6; i++) begin
      a = 8'($urandom_range(0, 255));
      mode = 3'($urandom_range(0, 7));
      cycle();
      chk("hold_ov", out_valid, 1'b0);
      chk("hold_y", y, exp_y);
      cnt_sel = 4'd0; #1;
      chk("hold_cnt0", cnt, exp_cnt[0]);
    end
    chk("final_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
